// File: rtl/rst_seq_pkg.sv
// Shared definitions for the multi-domain reset sequencer: FSM state encoding and width helpers.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_t;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1)
            return 1;
        return $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_counter.sv
// Saturating up-counter with synchronous clear, enable and a registered-count terminal flag.
module rst_seq_counter
    import rst_seq_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         CLK_generic,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         term
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK_generic) begin
        if (clr)
            cnt <= '0;
        else if (en && (cnt != '1))
            cnt <= cnt + W'(1);
    end

    assign term = (cnt >= limit);

endmodule

// File: rtl/rst_sequencer.sv
// Multi-domain reset sequencer: hold all domain resets after ready, then release them in index order.
// Optional ready-drop glitch filter enabled by defining RST_SEQ_FILTER_EN.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_DOM       = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic             CLK_generic,
    input  logic             RST_stimulus,
    input  logic [N_DOM-1:0] IRDY,
    output logic [N_DOM-1:0] DOMAIN_RST,
    output logic             SEQ_DONE,
    output logic             SEQ_RESTART,
    output logic [1:0]       SEQ_STATE
);

    localparam int unsigned CW = cnt_width(max2(HOLD_CYCLES, GAP_CYCLES));
    localparam int unsigned IW = cnt_width(N_DOM);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LIM  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DOM - 1);

    seq_state_t       state;
    logic [N_DOM-1:0] domain_rst;
    logic             seq_done;
    logic             seq_restart;
    logic [IW-1:0]    rel_idx;

    logic             irdy_all;
    logic             rdy_lost;
    logic             tmr_clr;
    logic             tmr_term;
    logic [CW-1:0]    tmr_limit;

    assign irdy_all = &IRDY;

`ifdef RST_SEQ_FILTER_EN
    localparam int unsigned FW = cnt_width(FILTER_LEN);
    logic flt_term;

    // Counts earlier consecutive low samples; the drop is acted on at the FILTER_LEN-th low sample.
    rst_seq_counter #(.W(FW)) u_filter (
        .CLK_generic (CLK_generic),
        .clr         (RST_stimulus | irdy_all),
        .en          (1'b1),
        .limit       (FW'(FILTER_LEN - 1)),
        .term        (flt_term)
    );

    assign rdy_lost = ~irdy_all & flt_term;
`else
    assign rdy_lost = ~irdy_all;
`endif

    always_comb begin
        tmr_limit = HOLD_LIM;
        if (state == ST_RELEASE)
            tmr_limit = GAP_LIM;
        tmr_clr = RST_stimulus | rdy_lost | tmr_term
                | (state == ST_WAIT) | (state == ST_RUN);
    end

    rst_seq_counter #(.W(CW)) u_timer (
        .CLK_generic (CLK_generic),
        .clr         (tmr_clr),
        .en          (1'b1),
        .limit       (tmr_limit),
        .term        (tmr_term)
    );

    always_ff @(posedge CLK_generic) begin
        if (RST_stimulus) begin
            state       <= ST_WAIT;
            domain_rst  <= '1;
            seq_done    <= 1'b0;
            seq_restart <= 1'b0;
            rel_idx     <= '0;
        end else begin
            seq_restart <= 1'b0;
            // Ready loss is checked ahead of the state case so it beats any release due this edge.
            if ((state != ST_WAIT) && rdy_lost) begin
                state       <= ST_WAIT;
                domain_rst  <= '1;
                seq_done    <= 1'b0;
                seq_restart <= 1'b1;
                rel_idx     <= '0;
            end else begin
                case (state)
                    ST_WAIT: begin
                        domain_rst <= '1;
                        seq_done   <= 1'b0;
                        rel_idx    <= '0;
                        if (irdy_all)
                            state <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (tmr_term) begin
                            if ((GAP_CYCLES == 0) || (N_DOM == 1)) begin
                                domain_rst <= '0;
                                seq_done   <= 1'b1;
                                state      <= ST_RUN;
                            end else begin
                                domain_rst[0] <= 1'b0;
                                rel_idx       <= IW'(1);
                                state         <= ST_RELEASE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (tmr_term) begin
                            for (int unsigned k = 0; k < N_DOM; k++) begin
                                if (rel_idx == IW'(k))
                                    domain_rst[k] <= 1'b0;
                            end
                            if (rel_idx == LAST_IDX) begin
                                seq_done <= 1'b1;
                                state    <= ST_RUN;
                            end else begin
                                rel_idx <= rel_idx + IW'(1);
                            end
                        end
                    end
                    ST_RUN: begin
                        seq_done <= 1'b1;
                    end
                    default: begin
                        state      <= ST_WAIT;
                        domain_rst <= '1;
                        seq_done   <= 1'b0;
                        rel_idx    <= '0;
                    end
                endcase
            end
        end
    end

    assign DOMAIN_RST  = domain_rst;
    assign SEQ_DONE    = seq_done;
    assign SEQ_RESTART = seq_restart;
    assign SEQ_STATE   = state;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected output-change events are queued by the stimulus
// and matched (value and cycle) by a monitor; a GAP_CYCLES=0 instance runs alongside.
module tb_rst_sequencer;

    logic       CLK_generic;
    logic       RST_stimulus;
    logic [2:0] IRDY;

    logic [2:0] dr0, dr1;
    logic       done0, done1, rp0, rp1;
    logic [1:0] st0, st1;

    typedef struct {
        int         cyc;
        logic [6:0] val;
    } evt_t;

    evt_t q0[$];
    evt_t q1[$];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   end_req = 1'b0;
    logic [6:0] prev0, prev1, snap0, snap1;

    rst_sequencer #(
        .N_DOM(3), .HOLD_CYCLES(16), .GAP_CYCLES(4), .FILTER_LEN(4)
    ) dut_gap4 (
        .CLK_generic (CLK_generic),
        .RST_stimulus(RST_stimulus),
        .IRDY        (IRDY),
        .DOMAIN_RST  (dr0),
        .SEQ_DONE    (done0),
        .SEQ_RESTART (rp0),
        .SEQ_STATE   (st0)
    );

    rst_sequencer #(
        .N_DOM(3), .HOLD_CYCLES(16), .GAP_CYCLES(0), .FILTER_LEN(4)
    ) dut_gap0 (
        .CLK_generic (CLK_generic),
        .RST_stimulus(RST_stimulus),
        .IRDY        (IRDY),
        .DOMAIN_RST  (dr1),
        .SEQ_DONE    (done1),
        .SEQ_RESTART (rp1),
        .SEQ_STATE   (st1)
    );

    initial begin
        CLK_generic = 1'b0;
        forever #5 CLK_generic = ~CLK_generic;
    end

    always @(posedge CLK_generic) cyc <= cyc + 1;

    // which: 0 = gap4 instance, 1 = gap0 instance, 2 = both
    task automatic push(input int which, input int c, input logic [2:0] dr,
                        input logic dn, input logic rp, input logic [1:0] st);
        evt_t e;
        e.cyc = c;
        e.val = {dr, dn, rp, st};
        if (which != 1) q0.push_back(e);
        if (which != 0) q1.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge CLK_generic);
            #1;
        end
        #1;
    endtask

    // Monitor: every change of an instance's outputs must match the next queued event.
    always @(negedge CLK_generic) begin
        evt_t e;
        snap0 = {dr0, done0, rp0, st0};
        snap1 = {dr1, done1, rp1, st1};
        if (snap0 !== prev0) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL gap4_unexpected: cycle %0d got {rst,done,restart,state}=%b, required no change",
                         cyc, snap0);
            end else begin
                e = q0.pop_front();
                if ((e.cyc != cyc) || (e.val !== snap0)) begin
                    n_bad++;
                    $display("FAIL gap4_event: got %b at cycle %0d, required %b at cycle %0d",
                             snap0, cyc, e.val, e.cyc);
                end
            end
        end
        if (snap1 !== prev1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL gap0_unexpected: cycle %0d got {rst,done,restart,state}=%b, required no change",
                         cyc, snap1);
            end else begin
                e = q1.pop_front();
                if ((e.cyc != cyc) || (e.val !== snap1)) begin
                    n_bad++;
                    $display("FAIL gap0_event: got %b at cycle %0d, required %b at cycle %0d",
                             snap1, cyc, e.val, e.cyc);
                end
            end
        end
        prev0 = snap0;
        prev1 = snap1;
        if (end_req) begin
            while (q0.size() > 0) begin
                e = q0.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL gap4_missing: got no change, required %b at cycle %0d", e.val, e.cyc);
            end
            while (q1.size() > 0) begin
                e = q1.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL gap0_missing: got no change, required %b at cycle %0d", e.val, e.cyc);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        int b, e0, e1;
        RST_stimulus = 1'b1;
        IRDY         = 3'b000;

        // Reset held three edges with IRDY low.
        push(2, 1, 3'b111, 1'b0, 1'b0, 2'd0);
        wait_cyc(3);
        RST_stimulus = 1'b0;

        // Full sequence, E0 = 6.
        wait_cyc(5);
        IRDY = 3'b111;
        push(2, 6, 3'b111, 1'b0, 1'b0, 2'd1);
        push(0, 22, 3'b110, 1'b0, 1'b0, 2'd2);
        push(0, 26, 3'b100, 1'b0, 1'b0, 2'd2);
        push(0, 30, 3'b000, 1'b1, 1'b0, 2'd3);
        push(1, 22, 3'b000, 1'b1, 1'b0, 2'd3);

`ifndef RST_SEQ_FILTER_EN
        // One-cycle drop in RUN, then a one-cycle drop at E0+18 of the restarted sequence.
        wait_cyc(35);
        push(2, 36, 3'b111, 1'b0, 1'b1, 2'd0);
        push(2, 37, 3'b111, 1'b0, 1'b0, 2'd1);
        push(0, 53, 3'b110, 1'b0, 1'b0, 2'd2);
        push(1, 53, 3'b000, 1'b1, 1'b0, 2'd3);
        push(2, 55, 3'b111, 1'b0, 1'b1, 2'd0);
        push(2, 56, 3'b111, 1'b0, 1'b0, 2'd1);
        push(0, 72, 3'b110, 1'b0, 1'b0, 2'd2);
        push(0, 76, 3'b100, 1'b0, 1'b0, 2'd2);
        push(0, 80, 3'b000, 1'b1, 1'b0, 2'd3);
        push(1, 72, 3'b000, 1'b1, 1'b0, 2'd3);
        IRDY = 3'b101;
        wait_cyc(36);
        IRDY = 3'b111;
        wait_cyc(54);
        IRDY = 3'b101;
        wait_cyc(55);
        IRDY = 3'b111;
        wait_cyc(84);
`else
        // Three-cycle glitch ignored; four-cycle drop aborts at its fourth low sample.
        wait_cyc(35);
        push(2, 46, 3'b111, 1'b0, 1'b1, 2'd0);
        push(2, 47, 3'b111, 1'b0, 1'b0, 2'd1);
        push(0, 63, 3'b110, 1'b0, 1'b0, 2'd2);
        push(0, 67, 3'b100, 1'b0, 1'b0, 2'd2);
        push(0, 71, 3'b000, 1'b1, 1'b0, 2'd3);
        push(1, 63, 3'b000, 1'b1, 1'b0, 2'd3);
        IRDY = 3'b011;
        wait_cyc(38);
        IRDY = 3'b111;
        wait_cyc(42);
        IRDY = 3'b011;
        wait_cyc(46);
        IRDY = 3'b111;
        wait_cyc(75);
`endif

        // Reset from RUN, then reset again mid-RELEASE with IRDY high: no restart pulse.
        b  = cyc;
        e0 = b + 2;
        e1 = e0 + 23;
        push(2, b + 1, 3'b111, 1'b0, 1'b0, 2'd0);
        push(2, e0, 3'b111, 1'b0, 1'b0, 2'd1);
        push(0, e0 + 16, 3'b110, 1'b0, 1'b0, 2'd2);
        push(0, e0 + 20, 3'b100, 1'b0, 1'b0, 2'd2);
        push(1, e0 + 16, 3'b000, 1'b1, 1'b0, 2'd3);
        push(2, e0 + 22, 3'b111, 1'b0, 1'b0, 2'd0);
        push(2, e1, 3'b111, 1'b0, 1'b0, 2'd1);
        push(0, e1 + 16, 3'b110, 1'b0, 1'b0, 2'd2);
        push(0, e1 + 20, 3'b100, 1'b0, 1'b0, 2'd2);
        push(0, e1 + 24, 3'b000, 1'b1, 1'b0, 2'd3);
        push(1, e1 + 16, 3'b000, 1'b1, 1'b0, 2'd3);
        RST_stimulus = 1'b1;
        wait_cyc(b + 1);
        RST_stimulus = 1'b0;
        wait_cyc(e0 + 21);
        RST_stimulus = 1'b1;
        wait_cyc(e0 + 22);
        RST_stimulus = 1'b0;
        wait_cyc(e1 + 28);
        end_req = 1'b1;
        repeat (10) @(posedge CLK_generic);
        $display("FAIL monitor_end: summary not reached, required within 10 cycles");
        $fatal(1);
    end

endmodule
